// File: rtl/npu_mem_initiator_if.sv
// Bundle of the host command/response streams and the NPU SRAM-like word port.
// Pure wiring, no latency of its own.
// Flow control is carried by the valid/ready pairs; the memory port has no backpressure.
interface npu_mem_initiator_if #(
  parameter int AXI_WIDTH = 32,
  parameter int ADDR_W    = 3
);
  logic                 flush;
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic                 cmd_write;
  logic [ADDR_W-1:0]    cmd_addr;
  logic [AXI_WIDTH-1:0] cmd_wdata;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [AXI_WIDTH-1:0] rsp_rdata;
  logic                 busy;
  logic                 req;
  logic [3:0]           wen;
  logic [ADDR_W-1:0]    addr;
  logic [AXI_WIDTH-1:0] wdata;
  logic [AXI_WIDTH-1:0] rdata;

  modport master (
    input  flush, cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, rdata,
    output cmd_ready, rsp_valid, rsp_rdata, busy, req, wen, addr, wdata
  );

  modport slave (
    output flush, cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, rdata,
    input  cmd_ready, rsp_valid, rsp_rdata, busy, req, wen, addr, wdata
  );
endinterface

// File: rtl/npu_mem_initiator.sv
// Queues host word commands and plays them in order onto the NPU SRAM port, returning read data.
// Latency: accept edge -> strobe after next edge; read data captured the cycle after its strobe.
// Backpressure: cmd_ready drops when the command FIFO is full; reads wait for response-FIFO credit.
module npu_mem_initiator #(
  parameter int AXI_WIDTH = 32,
  parameter int ADDR_W    = 3,
  parameter int CMD_DEPTH = 4,
  parameter int RSP_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  npu_mem_initiator_if.master bus
);
  localparam int CPW = $clog2(CMD_DEPTH);
  localparam int CCW = CPW + 1;
  localparam int RPW = $clog2(RSP_DEPTH);
  localparam int RCW = RPW + 1;
  localparam int SW  = RCW + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, STALL = 2'd2} state_t;
  state_t state, next_state;

  logic                 cmd_wr_q   [CMD_DEPTH];
  logic [ADDR_W-1:0]    cmd_addr_q [CMD_DEPTH];
  logic [AXI_WIDTH-1:0] cmd_data_q [CMD_DEPTH];
  logic [CPW-1:0]       cmd_wr_ptr, cmd_rd_ptr, cmd_rd_nxt;
  logic [CCW-1:0]       cmd_count, cmd_count_nxt, cnt_after_pop;
  logic                 cmd_push, issue, issue_rd, head_wr_nxt;

  logic [AXI_WIDTH-1:0] rsp_mem [RSP_DEPTH];
  logic [RPW-1:0]       rsp_wr_ptr, rsp_rd_ptr;
  logic [RCW-1:0]       rsp_count, rsp_count_nxt;
  logic [SW-1:0]        credit_sum;
  logic                 rsp_push, rsp_pop, rd_strobe, rd_pend;

  assign bus.cmd_ready = (cmd_count != CCW'(CMD_DEPTH));
  assign cmd_push      = bus.cmd_valid && bus.cmd_ready && !bus.flush;
  assign rd_strobe     = bus.req && (bus.wen == 4'h0);
  assign rsp_push      = rd_pend;
  assign bus.rsp_valid = (rsp_count != '0);
  assign rsp_pop       = bus.rsp_valid && bus.rsp_ready;
  assign bus.rsp_rdata = bus.rsp_valid ? rsp_mem[rsp_rd_ptr] : '0;
  assign bus.busy      = (cmd_count != '0) || bus.req || rd_pend || bus.rsp_valid;

  // State register: holds the classification of the command at the FIFO head for this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next state: look ahead to the FIFO head and read credit as they will stand after this edge,
  // so a freshly accepted command can issue on the very next edge.
  always_comb begin
    cnt_after_pop = cmd_count - CCW'(issue);
    cmd_count_nxt = bus.flush ? '0 : cnt_after_pop + CCW'(cmd_push);
    cmd_rd_nxt    = bus.flush ? cmd_wr_ptr : cmd_rd_ptr + CPW'(issue);
    head_wr_nxt   = (cnt_after_pop == '0) ? bus.cmd_write : cmd_wr_q[cmd_rd_nxt];
    rsp_count_nxt = rsp_count + RCW'(rsp_push) - RCW'(rsp_pop);
    // Reads outstanding next cycle: the strobe issued now plus the one whose data is due now.
    credit_sum    = SW'(rsp_count_nxt) + SW'(issue_rd) + SW'(rd_strobe);
    next_state    = STALL;
    if (cmd_count_nxt == '0)
      next_state = IDLE;
    else if (head_wr_nxt || (credit_sum < SW'(RSP_DEPTH)))
      next_state = ISSUE;
  end

  // Outputs of the FSM: pop/issue the head; a flush cancels anything not yet on the port.
  always_comb begin
    issue    = 1'b0;
    issue_rd = 1'b0;
    if ((state == ISSUE) && !bus.flush) begin
      issue    = 1'b1;
      issue_rd = !cmd_wr_q[cmd_rd_ptr];
    end
  end

  // Command FIFO storage; contents need no reset since the count gates every use.
  always_ff @(posedge clk) begin
    if (cmd_push) begin
      cmd_wr_q[cmd_wr_ptr]   <= bus.cmd_write;
      cmd_addr_q[cmd_wr_ptr] <= bus.cmd_addr;
      cmd_data_q[cmd_wr_ptr] <= bus.cmd_wdata;
    end
  end

  // Command FIFO pointers and occupancy; flush realigns the read pointer onto the write pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_wr_ptr <= '0;
      cmd_rd_ptr <= '0;
      cmd_count  <= '0;
    end else begin
      if (cmd_push) cmd_wr_ptr <= cmd_wr_ptr + CPW'(1);
      cmd_rd_ptr <= cmd_rd_nxt;
      cmd_count  <= cmd_count_nxt;
    end
  end

  // Registered memory port: one strobe per issued command, all zero on idle cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.req   <= 1'b0;
      bus.wen   <= 4'h0;
      bus.addr  <= '0;
      bus.wdata <= '0;
      rd_pend   <= 1'b0;
    end else begin
      rd_pend <= rd_strobe;
      if (issue) begin
        bus.req   <= 1'b1;
        bus.wen   <= cmd_wr_q[cmd_rd_ptr] ? 4'hF : 4'h0;
        bus.addr  <= cmd_addr_q[cmd_rd_ptr];
        bus.wdata <= cmd_wr_q[cmd_rd_ptr] ? cmd_data_q[cmd_rd_ptr] : '0;
      end else begin
        bus.req   <= 1'b0;
        bus.wen   <= 4'h0;
        bus.addr  <= '0;
        bus.wdata <= '0;
      end
    end
  end

  // Response FIFO storage: captures rdata in the cycle after a read strobe.
  always_ff @(posedge clk) begin
    if (rsp_push) rsp_mem[rsp_wr_ptr] <= bus.rdata;
  end

  // Response FIFO pointers and occupancy; simultaneous push and pop keep the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_wr_ptr <= '0;
      rsp_rd_ptr <= '0;
      rsp_count  <= '0;
    end else begin
      if (rsp_push) rsp_wr_ptr <= rsp_wr_ptr + RPW'(1);
      if (rsp_pop)  rsp_rd_ptr <= rsp_rd_ptr + RPW'(1);
      rsp_count <= rsp_count_nxt;
    end
  end
endmodule

// File: tb/tb_npu_mem_initiator.sv
// Self-checking bench: directed scenarios plus a randomized command stream.
// Expected strobes and responses come from an in-order word-memory model.
// An SRAM behavioural model answers reads one cycle after the strobe.
module tb_npu_mem_initiator;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  npu_mem_initiator_if #(.AXI_WIDTH(32), .ADDR_W(3)) bus ();

  npu_mem_initiator #(.AXI_WIDTH(32), .ADDR_W(3), .CMD_DEPTH(4), .RSP_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit rand_rdy = 1'b0;

  typedef logic [38:0] acc_t;  // {addr, wen, wdata}
  logic [31:0] sram [8];
  logic [31:0] model_mem [8];
  acc_t        acc_q[$], exp_acc[$];
  int          acc_cyc[$];
  logic [31:0] rsp_q[$], exp_rsp[$];

  always @(posedge clk) cyc <= cyc + 1;

  // SRAM: write on a write strobe, read data registered so it is valid the cycle after the strobe.
  always @(posedge clk) begin
    if (bus.req && bus.wen == 4'hF) sram[bus.addr] <= bus.wdata;
    if (bus.req && bus.wen == 4'h0) bus.rdata <= sram[bus.addr];
    else                            bus.rdata <= 32'hBAD0_BAD0;
  end

  // Observe strobes and accepted responses mid-cycle.
  always @(negedge clk) begin
    if (rst_n && bus.req) begin
      acc_q.push_back({bus.addr, bus.wen, bus.wdata});
      acc_cyc.push_back(cyc);
    end
    if (rst_n && bus.rsp_valid && bus.rsp_ready) rsp_q.push_back(bus.rsp_rdata);
  end

  // Random response backpressure during the randomized phase.
  always @(posedge clk) begin
    #2;
    if (rand_rdy) bus.rsp_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: commands take effect in acceptance order.
  task automatic model_accept(input logic w, input logic [2:0] a, input logic [31:0] d);
    exp_acc.push_back({a, w ? 4'hF : 4'h0, w ? d : 32'h0});
    if (w) model_mem[a] = d;
    else   exp_rsp.push_back(model_mem[a]);
  endtask

  // Called at posedge+1; presents a command until accepted or max_wait cycles pass.
  task automatic try_push(input logic w, input logic [2:0] a, input logic [31:0] d,
                          input int max_wait, output bit ok);
    int n = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    @(negedge clk);
    while (!(bus.cmd_ready && !bus.flush) && n < max_wait) begin
      @(negedge clk);
      n++;
    end
    ok = bus.cmd_ready && !bus.flush;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    if (ok) model_accept(w, a, d);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    @(negedge clk);
    while (bus.busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_idle"}, 64'(bus.busy), 64'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic cmp_queues(input string tag);
    chk({tag, "_nacc"}, 64'(acc_q.size()), 64'(exp_acc.size()));
    for (int i = 0; i < acc_q.size() && i < exp_acc.size(); i++)
      chk({tag, "_acc"}, 64'(acc_q[i]), 64'(exp_acc[i]));
    chk({tag, "_nrsp"}, 64'(rsp_q.size()), 64'(exp_rsp.size()));
    for (int i = 0; i < rsp_q.size() && i < exp_rsp.size(); i++)
      chk({tag, "_rsp"}, 64'(rsp_q[i]), 64'(exp_rsp[i]));
    acc_q.delete(); acc_cyc.delete(); rsp_q.delete();
    exp_acc.delete(); exp_rsp.delete();
  endtask

  initial begin
    bit          ok;
    logic        w;
    logic [2:0]  a;
    logic [31:0] d;
    bus.flush = 1'b0; bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0;
    bus.cmd_addr = 3'd0; bus.cmd_wdata = 32'h0; bus.rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sram[i]      = 32'hDEAD_BEEF ^ (32'h0101_0101 * 32'(i));
      model_mem[i] = 32'hDEAD_BEEF ^ (32'h0101_0101 * 32'(i));
    end

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'(1));
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    chk("rst_busy",      64'(bus.busy),      64'(0));
    chk("rst_req",       64'(bus.req),       64'(0));
    chk("rst_wen",       64'(bus.wen),       64'(0));
    chk("rst_addr",      64'(bus.addr),      64'(0));
    chk("rst_wdata",     64'(bus.wdata),     64'(0));
    chk("rst_rdata",     64'(bus.rsp_rdata), 64'(0));
    rst_n = 1'b1;
    tick();

    // 1: write then read of word 0, cycle by cycle
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = 3'd0; bus.cmd_wdata = 32'h0100_0000;
    @(negedge clk); chk("t1_rdy", 64'(bus.cmd_ready), 64'(1));
    tick(); model_accept(1'b1, 3'd0, 32'h0100_0000);
    bus.cmd_write = 1'b0;
    @(negedge clk); chk("t1_no_req_yet", 64'(bus.req), 64'(0));
    tick(); model_accept(1'b0, 3'd0, 32'h0); bus.cmd_valid = 1'b0;
    @(negedge clk);
    chk("t1_wr_req",   64'(bus.req),   64'(1));
    chk("t1_wr_wen",   64'(bus.wen),   64'(4'hF));
    chk("t1_wr_wdata", 64'(bus.wdata), 64'(32'h0100_0000));
    tick(); @(negedge clk);
    chk("t1_rd_req", 64'(bus.req), 64'(1));
    chk("t1_rd_wen", 64'(bus.wen), 64'(0));
    tick(); @(negedge clk);
    chk("t1_gap_req",   64'(bus.req),       64'(0));
    chk("t1_gap_valid", 64'(bus.rsp_valid), 64'(0));
    chk("t1_gap_busy",  64'(bus.busy),      64'(1));
    tick(); @(negedge clk);
    chk("t1_rsp_valid", 64'(bus.rsp_valid), 64'(1));
    chk("t1_rsp_data",  64'(bus.rsp_rdata), 64'(model_mem[0]));
    tick(); @(negedge clk);
    chk("t1_done_busy", 64'(bus.busy), 64'(0));
    tick();
    cmp_queues("t1");

    // 2: four back-to-back writes to words 1..4
    for (int i = 1; i <= 4; i++) begin
      bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = 3'(i); bus.cmd_wdata = $urandom;
      @(negedge clk); chk("t2_rdy", 64'(bus.cmd_ready), 64'(1));
      tick(); model_accept(1'b1, 3'(i), bus.cmd_wdata);
    end
    bus.cmd_valid = 1'b0;
    repeat (4) tick();
    chk("t2_nstrobe", 64'(acc_q.size()), 64'(4));
    for (int i = 0; i < acc_q.size() && i < 4; i++) begin
      chk("t2_addr", 64'(acc_q[i][38:36]), 64'(i + 1));
      chk("t2_consec", 64'(acc_cyc[i] - acc_cyc[0]), 64'(i));
    end
    cmp_queues("t2");

    // 3: six reads with the consumer stalled
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      try_push(1'b0, 3'(i), 32'h0, 50, ok);
      chk("t3_push", 64'(ok), 64'(1));
    end
    repeat (6) tick();
    chk("t3_nstrobe", 64'(acc_q.size()), 64'(4));
    chk("t3_req_low", 64'(bus.req), 64'(0));
    chk("t3_rsp_vld", 64'(bus.rsp_valid), 64'(1));

    // 4: fill the command FIFO behind the stall
    d = $urandom; try_push(1'b1, 3'd6, d, 10, ok); chk("t4_push6", 64'(ok), 64'(1));
    d = $urandom; try_push(1'b1, 3'd7, d, 10, ok); chk("t4_push7", 64'(ok), 64'(1));
    @(negedge clk); chk("t4_full", 64'(bus.cmd_ready), 64'(0));
    tick();
    try_push(1'b1, 3'd1, 32'h1234_5678, 3, ok);
    chk("t4_refused", 64'(ok), 64'(0));
    chk("t4_nstrobe", 64'(acc_q.size()), 64'(4));
    bus.rsp_ready = 1'b1;
    wait_idle(100, "t34");
    cmp_queues("t34");

    // 5: flush on the cycle of the first read strobe
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 3'd1;
    tick(); model_accept(1'b0, 3'd1, 32'h0); bus.cmd_addr = 3'd2;
    tick(); bus.flush = 1'b1; bus.cmd_addr = 3'd3;
    @(negedge clk);
    chk("t5_strobe",      64'(bus.req),  64'(1));
    chk("t5_strobe_addr", 64'(bus.addr), 64'(1));
    tick(); bus.flush = 1'b0; bus.cmd_valid = 1'b0;
    @(negedge clk);
    chk("t5_no_req", 64'(bus.req),       64'(0));
    chk("t5_busy",   64'(bus.busy),      64'(1));
    chk("t5_empty",  64'(bus.cmd_ready), 64'(1));
    wait_idle(20, "t5");
    cmp_queues("t5");

    // 6: asynchronous reset with a read in flight
    try_push(1'b0, 3'd2, 32'h0, 10, ok); chk("t6_push", 64'(ok), 64'(1));
    @(negedge clk); chk("t6_pre", 64'(bus.req), 64'(0));
    tick(); @(negedge clk); chk("t6_strobe", 64'(bus.req), 64'(1));
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("t6_req",   64'(bus.req),       64'(0));
    chk("t6_wen",   64'(bus.wen),       64'(0));
    chk("t6_addr",  64'(bus.addr),      64'(0));
    chk("t6_vld",   64'(bus.rsp_valid), 64'(0));
    chk("t6_rdata", 64'(bus.rsp_rdata), 64'(0));
    chk("t6_busy",  64'(bus.busy),      64'(0));
    chk("t6_ready", 64'(bus.cmd_ready), 64'(1));
    acc_q.delete(); acc_cyc.delete(); rsp_q.delete(); exp_acc.delete(); exp_rsp.delete();
    @(negedge clk); rst_n = 1'b1;
    repeat (5) tick();
    chk("t6_no_rsp",    64'(rsp_q.size()), 64'(0));
    chk("t6_no_strobe", 64'(acc_q.size()), 64'(0));
    chk("t6_idle",      64'(bus.busy),     64'(0));

    // Randomized stream with random response backpressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      w = 1'($urandom_range(0, 1));
      a = 3'($urandom_range(0, 7));
      d = $urandom;
      try_push(w, a, d, 200, ok);
      chk("rnd_push", 64'(ok), 64'(1));
      repeat ($urandom_range(0, 2)) tick();
    end
    rand_rdy = 1'b0;
    bus.rsp_ready = 1'b1;
    wait_idle(300, "rnd");
    cmp_queues("rnd");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
